// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and one uart_tx start/busy port.
// The arbiter takes the master modport and the requester/transmitter side takes the slave modport.
interface uart_tx_arbiter_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant;
  logic [31:0] bytes_sent;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_data, tx_start, grant, bytes_sent
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_data, tx_start, grant, bytes_sent
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx between two byte requesters; tx_start/ready one cycle after valid, then frame wait and GAP_CYCLES hold-off.
// Requesters hold valid until their one-cycle ready; the optional boot hold-off is enabled by TXARB_STARTUP_DELAY_EN.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 1000,
  parameter int STARTUP_CYCLES = 20000
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_STARTUP,
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

`ifdef TXARB_STARTUP_DELAY_EN
  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SW-1:0] SU_LAST = (STARTUP_CYCLES > 0) ? SW'(STARTUP_CYCLES - 1) : '0;
  localparam state_t RESET_STATE = S_STARTUP;
  logic [SW-1:0] su_cnt;
`else
  localparam state_t RESET_STATE = S_IDLE;
  logic unused_startup;
  assign unused_startup = ^STARTUP_CYCLES;
`endif

  state_t        state;
  logic          req0_ready_q;
  logic          req1_ready_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic [1:0]    grant_q;
  logic [31:0]   sent_cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_grant;   // 1: port 1 owned the previous transaction
  logic          win0;
  logic          win1;

  // Port 0 wins alone, or on a tie when port 1 was served last.
  assign win0 = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign win1 = bus.req1_valid & ~win0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_STATE;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      grant_q      <= 2'b00;
      sent_cnt     <= 32'd0;
      gap_cnt      <= '0;
      last_grant   <= 1'b1;
`ifdef TXARB_STARTUP_DELAY_EN
      su_cnt       <= '0;
`endif
    end else begin
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      tx_start_q   <= 1'b0;
      case (state)
`ifdef TXARB_STARTUP_DELAY_EN
        S_STARTUP: begin
          if (su_cnt == SU_LAST) state <= S_IDLE;
          else                   su_cnt <= su_cnt + 1'b1;
        end
`endif
        S_IDLE: begin
          if (win0 | win1) begin
            tx_data_q    <= win0 ? bus.req0_data : bus.req1_data;
            grant_q      <= {win1, win0};
            last_grant   <= win1;
            tx_start_q   <= 1'b1;
            req0_ready_q <= win0;
            req1_ready_q <= win1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (bus.tx_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            sent_cnt <= sent_cnt + 32'd1;
            if (GAP_CYCLES == 0) begin
              grant_q <= 2'b00;
              state   <= S_IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            grant_q <= 2'b00;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = req0_ready_q;
  assign bus.req1_ready = req1_ready_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.grant      = grant_q;
  assign bus.bytes_sent = sent_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut_a (GAP_CYCLES=4) and dut_b (GAP_CYCLES=0), each driving a 10-cycle busy uart_tx model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arbiter_if bus_a ();
  uart_tx_arbiter_if bus_b ();

  uart_tx_arbiter #(.GAP_CYCLES(4), .STARTUP_CYCLES(50)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  uart_tx_arbiter #(.GAP_CYCLES(0), .STARTUP_CYCLES(50)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // uart_tx models: busy rises the edge after tx_start and stays high 10 cycles
  logic busy_a, busy_b;
  int   cnt_a, cnt_b, fall_a, fall_b;
  assign bus_a.tx_busy = busy_a;
  assign bus_b.tx_busy = busy_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_a <= 1'b0; cnt_a <= 0;
    end else if (bus_a.tx_start) begin
      busy_a <= 1'b1; cnt_a <= 10;
    end else if (cnt_a > 1) begin
      cnt_a <= cnt_a - 1;
    end else if (cnt_a == 1) begin
      cnt_a <= 0; busy_a <= 1'b0; fall_a <= cyc + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_b <= 1'b0; cnt_b <= 0;
    end else if (bus_b.tx_start) begin
      busy_b <= 1'b1; cnt_b <= 10;
    end else if (cnt_b > 1) begin
      cnt_b <= cnt_b - 1;
    end else if (cnt_b == 1) begin
      cnt_b <= 0; busy_b <= 1'b0; fall_b <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_launch(input int which, input string tag, output int e);
    logic hit;
    hit = 1'b0;
    e   = -1;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(posedge clk); #1;
      hit = (which == 0) ? bus_a.tx_start : bus_b.tx_start;
      if (hit) e = cyc;
    end
    check({tag, "_launch_seen"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input int which, input string tag);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(posedge clk); #1;
      idle = (which == 0) ? (bus_a.grant == 2'b00) : (bus_b.grant == 2'b00);
    end
    check({tag, "_idle_seen"}, 32'(idle), 32'd1);
  endtask

  int e;
  int first_k;
  int exp_first;
  logic [1:0] exp_g;

  initial begin
    bus_a.req0_valid = 1'b0; bus_a.req0_data = 8'h00;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 8'h9C;
    bus_b.req0_valid = 1'b0; bus_b.req0_data = 8'h00;
    bus_b.req1_valid = 1'b0; bus_b.req1_data = 8'h00;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(bus_a.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus_a.req1_ready), 32'd0);
    check("rst_tx_start",   32'(bus_a.tx_start),   32'd0);
    check("rst_tx_data",    32'(bus_a.tx_data),    32'h00);
    check("rst_grant",      32'(bus_a.grant),      32'd0);
    check("rst_bytes_sent", bus_a.bytes_sent,      32'd0);

    // Startup: req1 valid since reset; first ready on edge 51 with hold-off, edge 1 without
    @(negedge clk);
    rst = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 200 && first_k < 0; k++) begin
      @(posedge clk); #1;
      if (bus_a.req1_ready) first_k = k;
    end
`ifdef TXARB_STARTUP_DELAY_EN
    exp_first = 51;
`else
    exp_first = 1;
`endif
    check("startup_first_ready_edge", 32'(first_k), 32'(exp_first));
    check("startup_grant",   32'(bus_a.grant),   32'b10);
    check("startup_tx_data", 32'(bus_a.tx_data), 32'h9C);
    @(posedge clk); #1;
    bus_a.req1_valid = 1'b0;
    check("startup_start_one_cycle", 32'(bus_a.tx_start), 32'd0);
    wait_idle(0, "startup");
    check("startup_bytes_sent", bus_a.bytes_sent, 32'd1);

    // Contention: both held valid, strict alternation starting with port 0
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h11;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      wait_launch(0, "contend", e);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("contend_grant",   32'(bus_a.grant), 32'(exp_g));
      check("contend_ready",   32'({bus_a.req1_ready, bus_a.req0_ready}), 32'(exp_g));
      check("contend_tx_data", 32'(bus_a.tx_data), (i % 2 == 0) ? 32'h11 : 32'h22);
      if (i > 0) check("contend_fall_to_start", 32'(e - fall_a), 32'd6);
    end
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    wait_idle(0, "contend");
    check("contend_bytes_sent", bus_a.bytes_sent, 32'd5);

    // Single port A5 on port 0 (port 1 served last, so no tie involved)
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'hA5;
    wait_launch(0, "single", e);
    check("single_tx_data", 32'(bus_a.tx_data),    32'hA5);
    check("single_grant",   32'(bus_a.grant),      32'b01);
    check("single_ready0",  32'(bus_a.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    check("single_ready0_drop", 32'(bus_a.req0_ready), 32'd0);
    wait_idle(0, "single");
    check("single_bytes_sent", bus_a.bytes_sent, 32'd6);
    check("single_tx_data_held", 32'(bus_a.tx_data), 32'hA5);

    // GAP_CYCLES=0: back-to-back re-grant two cycles after busy falls
    bus_b.req0_valid = 1'b1; bus_b.req0_data = 8'h77;
    wait_launch(1, "gap0_first", e);
    check("gap0_grant", 32'(bus_b.grant), 32'b01);
    wait_launch(1, "gap0_second", e);
    check("gap0_fall_to_start", 32'(e - fall_b), 32'd2);
    check("gap0_tx_data", 32'(bus_b.tx_data), 32'h77);
    @(posedge clk); #1;
    bus_b.req0_valid = 1'b0;
    wait_idle(1, "gap0");
    check("gap0_bytes_sent", bus_b.bytes_sent, 32'd2);

    // Reset pulsed while waiting for the frame to end
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h3C;
    wait_launch(0, "midrst", e);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    for (int k = 0; k < 20 && !busy_a; k++) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_seen", 32'(busy_a), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_tx_start",   32'(bus_a.tx_start),   32'd0);
    check("midrst_grant",      32'(bus_a.grant),      32'd0);
    check("midrst_ready0",     32'(bus_a.req0_ready), 32'd0);
    check("midrst_bytes_sent", bus_a.bytes_sent,      32'd0);
    #1 rst = 1'b0;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h5A;
    wait_launch(0, "restart", e);
    check("restart_grant",   32'(bus_a.grant),   32'b01);
    check("restart_tx_data", 32'(bus_a.tx_data), 32'h5A);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    wait_idle(0, "restart");
    check("restart_bytes_sent", bus_a.bytes_sent, 32'd1);

    // Counter wrap
    @(negedge clk);
    force dut_a.sent_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.sent_cnt;
    #1;
    check("wrap_preload", bus_a.bytes_sent, 32'hFFFF_FFFF);
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'hC3;
    wait_launch(0, "wrap", e);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    wait_idle(0, "wrap");
    check("wrap_bytes_sent", bus_a.bytes_sent, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between two byte-stream requesters: port 0 is the core's output path and port 1 is the loader/ROM streamer. It arbitrates round-robin and launches one byte at a time into the transmitter. It waits for the frame to finish, then enforces a programmable inter-byte gap before granting again. It sits between the requesters and the uart_tx start/busy interface, and replaces ad-hoc start-delay counters in individual senders.

## Interface
- GAP_CYCLES, default 1000: idle cycles inserted after each completed frame before the next grant; 0 allowed.
- STARTUP_CYCLES, default 20000: post-reset hold-off, used only when TXARB_STARTUP_DELAY_EN is defined.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 has a byte; req0_data must be held stable while high until accepted.
- req0_data  in  8  port 0 byte.
- req0_ready  out  1  one-cycle accept pulse for port 0.
- req1_valid, req1_data, req1_ready: same as port 0, for port 1.
- tx_data  out  8  byte presented to uart_tx; held from capture until the next capture.
- tx_start  out  1  one-cycle launch pulse to uart_tx.
- tx_busy  in  1  uart_tx frame in progress.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- bytes_sent  out  32  count of completed frames; wraps modulo 2^32.

## Operation
- All outputs are registered.
- Reset values: req0_ready=0, req1_ready=0, tx_start=0, tx_data=8'h00, grant=00, bytes_sent=0, gap counter=0, last-grant pointer=1 (so port 0 wins the first tie).
- Reset state: S_STARTUP with the macro defined, otherwise S_IDLE.
- S_STARTUP: counts STARTUP_CYCLES clocks, ignores all valids, then goes to S_IDLE.
- S_IDLE arbitration:
  - If exactly one valid is high, that port wins.
  - If both are high, the port not granted last wins (round-robin).
  - If neither is high, stay in S_IDLE.
  - On a win: capture the winner's data into tx_data, set grant and the last-grant pointer, go to S_LAUNCH.
- S_LAUNCH, exactly one cycle: tx_start=1 and the winner's ready=1; go to S_WAIT_BUSY.
- S_WAIT_BUSY: wait for tx_busy=1, then go to S_WAIT_DONE. There is no timeout.
- S_WAIT_DONE: on tx_busy=0, increment bytes_sent.
  - GAP_CYCLES=0: go to S_IDLE and clear grant.
  - Otherwise: load the gap counter with GAP_CYCLES-1 and go to S_GAP.
- S_GAP: decrement the counter; at 0 go to S_IDLE and clear grant.
- Valids are not sampled outside S_IDLE. A requester that drops valid before it is accepted loses nothing.
- Reset asserted mid-operation immediately forces every output to its reset value, including tx_start=0 and ready=0. The in-flight byte is abandoned.

## Timing
- Grant latency: valid seen at edge N (in S_IDLE) gives S_LAUNCH with tx_start/ready high for cycle N..N+1. tx_data is valid from edge N onward.
- The requester may change data or valid at the edge that ends its ready cycle.
- Issue rate: one byte per (uart frame time + 1 launch cycle + busy-rise latency + GAP_CYCLES + 1 idle cycle).
- tx_busy falling is sampled once. bytes_sent updates at the edge after the fall is seen.
- Back-to-back: a requester holding valid continuously is re-granted on the first S_IDLE cycle, unless the other port is also valid. In that case the ports alternate strictly.

## Configuration
- TXARB_STARTUP_DELAY_EN defined: reset enters S_STARTUP, and no grant occurs before STARTUP_CYCLES+1 cycles after rst deasserts. This lets the receiving core finish boot.
- TXARB_STARTUP_DELAY_EN undefined: reset enters S_IDLE directly, S_STARTUP and its counter are not synthesized, and the first grant can occur on the first edge after reset.

## Test plan
- Single port: req0 sends 8'hA5 with GAP_CYCLES=4 and a model uart_tx (busy 10 cycles) -> one tx_start, tx_data=A5, req0_ready one cycle, bytes_sent=1, next grant no earlier than 4 cycles after busy falls.
- Contention: req0 and req1 held valid with 0x11 and 0x22 for 4 bytes -> grant order 01,10,01,10; tx_data sequence 11,22,11,22.
- GAP_CYCLES=0 -> S_WAIT_DONE goes straight to S_IDLE; the next tx_start comes exactly 2 cycles after busy falls.
- Reset mid-frame (rst pulsed during S_WAIT_DONE) -> tx_start, grant and ready are 0 asynchronously, bytes_sent=0, and the FSM restarts cleanly on the next request.
- Macro defined, STARTUP_CYCLES=50, req1 valid from reset -> no ready before cycle 51 after reset release, then a normal grant.
- Wrap: preload bytes_sent to 32'hFFFFFFFF via force, complete one frame -> bytes_sent reads 0.
